// File: rtl/prog_loader.sv
// Serial program loader: parses a SYNC/LEN/words/CHK byte frame and writes
// 18-bit instruction words into program memory while holding the CPU in reset.
module prog_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        prog_we_o,
    output logic [9:0]  prog_addr_o,
    output logic [17:0] prog_data_o,
    output logic        cpu_hold_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_HI = 4'd1,
        S_LEN_LO = 4'd2,
        S_B2     = 4'd3,
        S_B1     = 4'd4,
        S_B0     = 4'd5,
        S_WRITE  = 4'd6,
        S_CHECK  = 4'd7,
        S_DONE   = 4'd8,
        S_ERROR  = 4'd9
    } state_t;

    state_t         state_q, state_d;
    // addr_q doubles as the word counter; bit 10 lets it step past word 1024 without wrapping
    logic [10:0]    addr_q, addr_d;
    logic [9:0]     len_q, len_d;
    logic [9:0]     word_q, word_d;
    logic [7:0]     chk_q, chk_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [9:0]     prog_addr_q, prog_addr_d;
    logic [17:0]    prog_data_q, prog_data_d;

    logic accept_s;
    logic waiting_s;
    logic tmo_hit_s;
    logic last_word_s;
    logic is_sync_s;

    assign accept_s    = rx_valid_i & rx_ready_o;
    assign is_sync_s   = (rx_data_i == SYNC_BYTE);
    assign waiting_s   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_B2) ||
                         (state_q == S_B1) || (state_q == S_B0) || (state_q == S_CHECK);
    assign tmo_hit_s   = waiting_s && !accept_s && (tmo_q == TMO_LAST);
    assign last_word_s = (addr_q == {1'b0, len_q});

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept_s && is_sync_s) begin
                    state_d = S_LEN_HI;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (accept_s) begin
                    state_d = (|rx_data_i[7:2]) ? S_ERROR : S_LEN_LO;
                end else if (tmo_hit_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO, S_B2, S_B1, S_B0: begin
                if (accept_s) begin
                    state_d = state_t'(state_q + 4'd1);
                end else if (tmo_hit_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = state_q;
                end
            end
            S_WRITE: begin
                state_d = last_word_s ? S_CHECK : S_B2;
            end
            S_CHECK: begin
                if (accept_s) begin
                    state_d = (rx_data_i == chk_q) ? S_DONE : S_ERROR;
                end else if (tmo_hit_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode
    always_comb begin
        rx_ready_o  = 1'b1;
        cpu_hold_o  = 1'b0;
        load_done_o = 1'b0;
        load_err_o  = 1'b0;
        prog_we_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                rx_ready_o = 1'b1;
            end
            S_LEN_HI, S_LEN_LO, S_B2, S_B1, S_B0, S_CHECK: begin
                cpu_hold_o = 1'b1;
            end
            S_WRITE: begin
                rx_ready_o = 1'b0;
                cpu_hold_o = 1'b1;
                prog_we_o  = 1'b1;
            end
            S_DONE: begin
                load_done_o = 1'b1;
            end
            S_ERROR: begin
                cpu_hold_o = 1'b1;
                load_err_o = 1'b1;
            end
            default: begin
                rx_ready_o = 1'b1;
            end
        endcase
    end

    assign prog_addr_o = prog_addr_q;
    assign prog_data_o = prog_data_q;

    // Datapath next-state: length, word assembly, checksum, address, timeout
    always_comb begin
        addr_d      = addr_q;
        len_d       = len_q;
        word_d      = word_q;
        chk_d       = chk_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        if (waiting_s && !accept_s && !tmo_hit_s) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = '0;
        end
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept_s && is_sync_s) begin
                    addr_d = 11'd0;
                    chk_d  = 8'd0;
                end else begin
                    addr_d = addr_q;
                end
            end
            S_LEN_HI: begin
                if (accept_s) begin
                    len_d[9:8] = rx_data_i[1:0];
                end else begin
                    len_d = len_q;
                end
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    len_d[7:0] = rx_data_i;
                end else begin
                    len_d = len_q;
                end
            end
            S_B2: begin
                if (accept_s) begin
                    word_d[9:8] = rx_data_i[1:0];
                    chk_d       = chk_q + rx_data_i;
                end else begin
                    word_d = word_q;
                end
            end
            S_B1: begin
                if (accept_s) begin
                    word_d[7:0] = rx_data_i;
                    chk_d       = chk_q + rx_data_i;
                end else begin
                    word_d = word_q;
                end
            end
            S_B0: begin
                // Capture address and word here so they are stable for the whole WRITE cycle
                if (accept_s) begin
                    prog_data_d = {word_q, rx_data_i};
                    prog_addr_d = addr_q[9:0];
                    chk_d       = chk_q + rx_data_i;
                end else begin
                    prog_data_d = prog_data_q;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 11'd1;
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            addr_q      <= 11'd0;
            len_q       <= 10'd0;
            word_q      <= 10'd0;
            chk_q       <= 8'd0;
            tmo_q       <= '0;
            prog_addr_q <= 10'd0;
            prog_data_q <= 18'd0;
        end else begin
            addr_q      <= addr_d;
            len_q       <= len_d;
            word_q      <= word_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized frames against a byte-level
// frame model, plus directed reset, timeout, length and full-load scenarios.
module tb_prog_loader;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready_o, prog_we_o, cpu_hold_o, load_done_o, load_err_o;
    logic [9:0]  prog_addr_o;
    logic [17:0] prog_data_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [27:0] mon_q[$];
    int          mon_t[$];
    logic [27:0] exp_q[$];
    bit          exp_done;

    always #5 clk = ~clk;

    prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready_o), .prog_we_o(prog_we_o), .prog_addr_o(prog_addr_o),
        .prog_data_o(prog_data_o), .cpu_hold_o(cpu_hold_o), .load_done_o(load_done_o),
        .load_err_o(load_err_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: one entry per cycle with the strobe high
    always @(negedge clk) begin
        if (prog_we_o === 1'b1) begin
            mon_q.push_back({prog_addr_o, prog_data_o});
            mon_t.push_back(cyc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        ok  = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (rx_ready_o) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 rx_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_byte: byte %h not accepted, rx_ready=%b, required 1 within 50 cycles", b, rx_ready_o);
        end
    endtask

    // Reference model: builds a frame and the writes/result it must produce
    task automatic send_frame(input int n, input bit bad, input int max_gap, input bit addr_data);
        logic [7:0]  fr[$];
        logic [9:0]  l;
        logic [7:0]  sum, b2, b1, b0;
        logic [9:0]  a;
        l   = 10'(n - 1);
        sum = 8'd0;
        exp_q.delete();
        fr.push_back(8'hA5);
        fr.push_back({6'd0, l[9:8]});
        fr.push_back(l[7:0]);
        for (int i = 0; i < n; i++) begin
            a  = 10'(i);
            if (addr_data) begin
                b2 = {6'($urandom), 2'b00};
                b1 = {6'd0, a[9:8]};
                b0 = a[7:0];
            end else begin
                b2 = 8'($urandom);
                b1 = ($urandom_range(3, 0) == 0) ? 8'hA5 : 8'($urandom);
                b0 = 8'($urandom);
            end
            exp_q.push_back({a, b2[1:0], b1, b0});
            sum = sum + b2 + b1 + b0;
            fr.push_back(b2);
            fr.push_back(b1);
            fr.push_back(b0);
        end
        exp_done = !bad;
        fr.push_back(bad ? sum + 8'($urandom_range(255, 1)) : sum);
        mon_q.delete();
        mon_t.delete();
        foreach (fr[i]) send_byte(fr[i], max_gap);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({rx_ready_o, prog_we_o, cpu_hold_o, load_done_o, load_err_o, prog_addr_o, prog_data_o} !== {1'b1, 4'b0, 10'd0, 18'd0}) begin
            fails++;
            $display("FAIL reset_outputs: ready/we/hold/done/err=%b%b%b%b%b addr=%h data=%h, required 10000 0 0",
                     rx_ready_o, prog_we_o, cpu_hold_o, load_done_o, load_err_o, prog_addr_o, prog_data_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_garbage_idle();
        mon_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        tests++;
        if ({rx_ready_o, cpu_hold_o, load_done_o, load_err_o} !== 4'b1000 || mon_q.size() != 0) begin
            fails++;
            $display("FAIL garbage_idle: ready/hold/done/err=%b%b%b%b writes=%0d, required 1000 and 0 writes",
                     rx_ready_o, cpu_hold_o, load_done_o, load_err_o, mon_q.size());
        end
    endtask

    task automatic test_single_word();
        logic [7:0] fr[6];
        fr = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h23, 8'h45};
        mon_q.delete();
        foreach (fr[i]) send_byte(fr[i], 0);
        tests++;
        if ({prog_we_o, prog_addr_o, prog_data_o} !== {1'b1, 10'd0, 18'h12345}) begin
            fails++;
            $display("FAIL single_latency: we=%b addr=%h data=%h one cycle after B0, required 1 000 12345",
                     prog_we_o, prog_addr_o, prog_data_o);
        end
        send_byte(8'h69, 0);
        tests++;
        if (mon_q.size() != 1 || mon_q[0] !== {10'd0, 18'h12345}) begin
            fails++;
            $display("FAIL single_write: writes=%0d first=%h, required 1 write of %h",
                     mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 28'd0, {10'd0, 18'h12345});
        end
        tests++;
        if ({load_done_o, load_err_o, cpu_hold_o} !== 3'b100) begin
            fails++;
            $display("FAIL single_status: done/err/hold=%b%b%b, required 100", load_done_o, load_err_o, cpu_hold_o);
        end
    endtask

    task automatic test_bad_checksum();
        send_frame(2, 1'b1, 2, 1'b0);
        tests++;
        if (mon_q.size() != 2 || mon_q[0] !== exp_q[0] || mon_q[1] !== exp_q[1]) begin
            fails++;
            $display("FAIL badchk_writes: writes=%0d, required 2 writes %h %h", mon_q.size(), exp_q[0], exp_q[1]);
        end
        tests++;
        if ({load_done_o, load_err_o, cpu_hold_o} !== 3'b011) begin
            fails++;
            $display("FAIL badchk_status: done/err/hold=%b%b%b, required 011", load_done_o, load_err_o, cpu_hold_o);
        end
    endtask

    task automatic test_length_error();
        mon_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        tests++;
        if ({load_done_o, load_err_o, cpu_hold_o} !== 3'b011 || mon_q.size() != 0) begin
            fails++;
            $display("FAIL length_error: done/err/hold=%b%b%b writes=%0d, required 011 and 0 writes",
                     load_done_o, load_err_o, cpu_hold_o, mon_q.size());
        end
    endtask

    task automatic test_timeout();
        int got;
        got = -1;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (load_err_o === 1'b1) begin
                got = c;
                break;
            end
        end
        tests++;
        if (got != TMO) begin
            fails++;
            $display("FAIL timeout_delay: load_err rose after %0d cycles, required %0d", got, TMO);
        end
        send_byte(8'hA5, 0);
        tests++;
        if ({load_done_o, load_err_o, cpu_hold_o} !== 3'b001) begin
            fails++;
            $display("FAIL timeout_restart: done/err/hold=%b%b%b, required 001", load_done_o, load_err_o, cpu_hold_o);
        end
        send_byte(8'h04, 0);
        tests++;
        if (load_err_o !== 1'b1) begin
            fails++;
            $display("FAIL timeout_lenhi: load_err=%b after bad LEN_HI, required 1", load_err_o);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] fr[5];
        fr = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h34};
        mon_q.delete();
        foreach (fr[i]) send_byte(fr[i], 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({rx_ready_o, prog_we_o, cpu_hold_o, load_done_o, load_err_o, prog_addr_o, prog_data_o} !== {1'b1, 4'b0, 10'd0, 18'd0}
            || mon_q.size() != 0) begin
            fails++;
            $display("FAIL midload_reset: ready/we/hold/done/err=%b%b%b%b%b writes=%0d, required 10000 and 0 writes",
                     rx_ready_o, prog_we_o, cpu_hold_o, load_done_o, load_err_o, mon_q.size());
        end
        rst_n = 1'b1;
        foreach (fr[i]) send_byte(fr[i], 0);
        send_byte(8'h56, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({rx_ready_o, prog_we_o, cpu_hold_o} !== 3'b100) begin
            fails++;
            $display("FAIL write_reset: ready/we/hold=%b%b%b after reset in WRITE, required 100",
                     rx_ready_o, prog_we_o, cpu_hold_o);
        end
        rst_n = 1'b1;
        send_frame(3, 1'b0, 2, 1'b0);
        tests++;
        if (mon_q.size() != 3 || mon_q[0] !== exp_q[0] || mon_q[2] !== exp_q[2] || load_done_o !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_load: writes=%0d first=%h done=%b, required 3 writes first %h done 1",
                     mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 28'd0, load_done_o, exp_q[0]);
        end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 8; it++) begin
            send_frame(int'($urandom_range(8, 1)), ($urandom_range(2, 0) == 0), 3, 1'b0);
            tests++;
            if (mon_q.size() != exp_q.size()) begin
                fails++;
                $display("FAIL rand_count[%0d]: writes=%0d, required %0d", it, mon_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    tests++;
                    if (mon_q[i] !== exp_q[i]) begin
                        fails++;
                        $display("FAIL rand_write[%0d.%0d]: got %h, required %h", it, i, mon_q[i], exp_q[i]);
                    end
                end
            end
            tests++;
            if ({load_done_o, load_err_o, cpu_hold_o} !== {exp_done, !exp_done, !exp_done}) begin
                fails++;
                $display("FAIL rand_status[%0d]: done/err/hold=%b%b%b, required %b%b%b", it,
                         load_done_o, load_err_o, cpu_hold_o, exp_done, !exp_done, !exp_done);
            end
        end
    endtask

    task automatic test_full_load();
        int bad_gap, bad_wr;
        bad_gap = 0;
        bad_wr  = 0;
        send_frame(1024, 1'b0, 0, 1'b1);
        tests++;
        if (mon_q.size() != 1024) begin
            fails++;
            $display("FAIL full_count: writes=%0d, required 1024", mon_q.size());
        end else begin
            foreach (exp_q[i]) if (mon_q[i] !== exp_q[i]) bad_wr++;
            for (int i = 1; i < 1024; i++) if (mon_t[i] - mon_t[i-1] != 4) bad_gap++;
            tests++;
            if (bad_wr != 0) begin
                fails++;
                $display("FAIL full_writes: %0d writes differ from address==data order, required 0", bad_wr);
            end
            tests++;
            if (bad_gap != 0) begin
                fails++;
                $display("FAIL back_to_back: %0d word gaps not 4 cycles, required 0", bad_gap);
            end
        end
        tests++;
        if ({load_done_o, load_err_o, cpu_hold_o} !== 3'b100) begin
            fails++;
            $display("FAIL full_status: done/err/hold=%b%b%b, required 100", load_done_o, load_err_o, cpu_hold_o);
        end
        send_byte(8'hA5, 0);
        tests++;
        if ({load_done_o, cpu_hold_o} !== 2'b01) begin
            fails++;
            $display("FAIL done_resync: done/hold=%b%b, required 01", load_done_o, cpu_hold_o);
        end
    endtask

    initial begin
        test_reset();
        test_garbage_idle();
        test_single_word();
        test_bad_checksum();
        test_length_error();
        test_timeout();
        test_reset_mid_load();
        test_random_frames();
        test_full_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between accepted bytes during a load.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset; synchronous, active-low.
REQ-005 RX_DATA  input  8  received byte from the serial receiver.
REQ-006 RX_VALID  input  1  RX_DATA valid.
REQ-007 RX_READY  output  1  loader can accept a byte.
REQ-008 PROG_WE  output  1  program-memory write strobe, one cycle per word.
REQ-009 PROG_ADDR  output  10  program-memory write address.
REQ-010 PROG_DATA  output  18  instruction word to write.
REQ-011 CPU_HOLD  output  1  holds the CPU in reset while a load is in progress or failed.
REQ-012 LOAD_DONE  output  1  last load completed with a good checksum.
REQ-013 LOAD_ERR  output  1  last load aborted.

Function
REQ-014 A byte SHALL be accepted only on a rising edge with RX_VALID=1 and RX_READY=1; when RX_READY=0, RX_DATA is ignored and the byte is neither consumed nor buffered.
REQ-015 The frame format SHALL be: SYNC_BYTE; LEN_HI; LEN_LO; N words of three bytes each (B2, B1, B0); CHK.
REQ-016 States SHALL be: IDLE, LEN_HI, LEN_LO, B2, B1, B0, WRITE, CHECK, DONE, ERROR.
REQ-017 IDLE, DONE, ERROR: an accepted SYNC_BYTE -> LEN_HI; clear word address, word counter, and checksum. Any other byte is discarded and the state is unchanged.
REQ-018 LEN_HI: an accepted byte with bits [7:2]≠0 -> ERROR; otherwise bits [1:0] become L[9:8] -> LEN_LO.
REQ-019 LEN_LO: the accepted byte becomes L[7:0] -> B2. The word count SHALL be N=L+1 (1..1024).
REQ-020 B2: byte[1:0] becomes word[17:16] and byte[7:2] is ignored -> B1. B1: byte becomes word[15:8] -> B0. B0: byte becomes word[7:0] -> WRITE.
REQ-021 The checksum SHALL be the mod-256 sum of every accepted data byte (B2, B1, B0 only; the full 8 bits of B2 are included). SYNC, LEN, and CHK bytes are excluded.
REQ-022 WRITE SHALL last exactly one cycle with PROG_WE=1, PROG_ADDR=current address, PROG_DATA=assembled word, and RX_READY=0.
REQ-023 On leaving WRITE, the address SHALL increment. If the written word was word N -> CHECK, else -> B2. Addresses run 0..N-1 and never wrap.
REQ-024 CHECK: accepted byte equal to checksum -> DONE; otherwise -> ERROR.
REQ-025 A SYNC_BYTE value inside LEN or data fields SHALL be treated as data; no resynchronisation occurs mid-frame.
REQ-026 Timeout counter: in LEN_HI, LEN_LO, B2, B1, B0, and CHECK it SHALL count cycles with no accepted byte and clear on each accept. When it reaches TIMEOUT_CYCLES the next state SHALL be ERROR. The counter is held at 0 in all other states.
REQ-027 Output decode (Moore, from state register):
- RX_READY=1 in all states except WRITE.
- CPU_HOLD=1 in LEN_HI..CHECK and in ERROR.
- LOAD_DONE=1 only in DONE; LOAD_ERR=1 only in ERROR.
- PROG_WE=1 only in WRITE.
REQ-028 PROG_ADDR and PROG_DATA SHALL hold their last values outside WRITE; they are valid only while PROG_WE=1.
REQ-029 Timing: latency from acceptance of B0 to PROG_WE=1 SHALL be exactly one cycle. Back-to-back words with RX_VALID held high therefore take 4 cycles per word.

Reset
REQ-030 RST_N=0 at a rising edge SHALL force IDLE and clear address, word counter, checksum, timeout counter, PROG_ADDR, and PROG_DATA to 0. Resulting outputs: RX_READY=1, all other outputs 0.
REQ-031 Reset asserted in any state, including WRITE, SHALL abort the load. No PROG_WE pulse occurs in the cycle after the reset edge. The next load starts again at address 0.

Verification
REQ-032 Single word: stream A5 00 00 01 23 45 69 -> one PROG_WE pulse, PROG_ADDR=0, PROG_DATA=18'h12345; LOAD_DONE=1, CPU_HOLD=0.
REQ-033 Bad checksum: A5 00 01 then two words, then CHK = correct+1 -> two writes at addr 0 and 1; LOAD_ERR=1, CPU_HOLD=1.
REQ-034 Length error: A5 04 -> ERROR immediately with no writes. Garbage bytes (00, FF) sent in IDLE before A5 -> ignored, state stays IDLE.
REQ-035 Timeout (TIMEOUT_CYCLES=16): A5 00 then RX_VALID=0 -> LOAD_ERR rises 16 cycles after the LEN_HI accept. A following A5 restarts the load into LEN_HI.
REQ-036 Reset mid-load: drop RST_N after B1 of word 0 -> IDLE, all outputs except RX_READY are 0, no write issued. A subsequent full frame writes starting at address 0.
REQ-037 Full load: A5 03 FF plus 1024 words with data = address -> addresses 0..1023 written in order, no wrap, LOAD_DONE=1. A5 sent while in DONE -> CPU_HOLD=1 again.
